// File: rtl/mips_pkg.sv
// Shared ALU control codes and mul/div engine types.
// Imported by the execute-stage ALU and its mul/div sequencer.
package mips_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [4:0] {
      ALU_AND   = 5'b00000,
      ALU_OR    = 5'b00001,
      ALU_ADD   = 5'b00010,
      ALU_SLL   = 5'b00011,
      ALU_SUB   = 5'b00110,
      ALU_SLT   = 5'b00111,
      ALU_LUI   = 5'b01000,
      ALU_XOR   = 5'b01001,
      ALU_BLEZ  = 5'b01010,
      ALU_SRLV  = 5'b01011,
      ALU_SRL   = 5'b01100,
      ALU_SRAV  = 5'b01101,
      ALU_SLTU  = 5'b01110,
      ALU_BGTZ  = 5'b10000,
      ALU_SRA   = 5'b10001,
      ALU_SLLV  = 5'b10010,
      ALU_MULT  = 5'b10011,
      ALU_MULTU = 5'b10100,
      ALU_DIV   = 5'b10101,
      ALU_DIVU  = 5'b10110,
      ALU_MFHI  = 5'b10111,
      ALU_MFLO  = 5'b11000
   } alucontrol_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIX
   } md_state_t;

   function automatic logic is_muldiv(input logic [4:0] c);
      return c inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
   endfunction

   function automatic logic is_hilo(input logic [4:0] c);
      return c inside {ALU_MFHI, ALU_MFLO};
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative mul/div engine: one bit per cycle on magnitudes,
// sign fix-up in a final cycle, then HI/LO update.
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int ITERS = WIDTH;
   localparam int CW    = $clog2(ITERS);

   md_state_t          state;
   md_state_t          state_nx;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opd;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz;

   logic               accept;
   logic               sgn;
   logic               div_op;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     rem_t;
   logic [WIDTH:0]     rem_d;
   logic               rem_ge;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign accept = start & (state == MD_IDLE);
   assign sgn    = (op == ALU_MULT) | (op == ALU_DIV);
   assign div_op = (op == ALU_DIV) | (op == ALU_DIVU);
   assign mag_a  = (sgn & a[WIDTH-1]) ? -a : a;
   assign mag_b  = (sgn & b[WIDTH-1]) ? -b : b;

   // restoring divide step: shift dividend bit into remainder
   assign rem_t  = {acc_hi, acc_lo[WIDTH-1]};
   assign rem_d  = rem_t - {1'b0, opd};
   assign rem_ge = rem_t >= {1'b0, opd};

   // shift-add multiply step on the low multiplier bit
   assign sum = {1'b0, acc_hi}
              + (acc_lo[0] ? {1'b0, opd} : '0);

   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   // divide by zero: all-ones quotient, remainder falls out as a
   assign quo_fix  = dz ? '1 : (neg_q ? -acc_lo : acc_lo);
   assign rem_fix  = neg_r ? -acc_hi : acc_hi;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= MD_IDLE;
      else        state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      case (state)
         MD_IDLE: if (accept) state_nx = MD_RUN;
         MD_RUN:  if (cnt == CW'(ITERS-1)) state_nx = MD_FIX;
         MD_FIX:  state_nx = MD_IDLE;
         default: state_nx = MD_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state != MD_IDLE);
   end

   // operand latch, iteration datapath and HI/LO write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         opd    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (accept) begin
         cnt    <= '0;
         opd    <= div_op ? mag_b : mag_a;
         acc_hi <= '0;
         acc_lo <= div_op ? mag_a : mag_b;
         is_div <= div_op;
         neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r  <= sgn & a[WIDTH-1];
         dz     <= div_op & (b == '0);
      end else if (state == MD_RUN) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            acc_hi <= rem_ge ? rem_d[WIDTH-1:0]
                             : rem_t[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
         end else begin
            {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
         end
      end else if (state == MD_FIX) begin
         if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
         end else begin
            {hi, lo} <= prod_fix;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational ops plus background mul/div
// with HI/LO; stalls only on HI/LO or mul/div hazards.
module alu_muldiv
   import mips_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [4:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             stall,
   output logic             busy
);

   alucontrol_t      code;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             md_op;
   logic             hl_op;
   logic             a_le0;

   assign code  = alucontrol_t'(alucontrol);
   assign md_op = is_muldiv(alucontrol);
   assign hl_op = is_hilo(alucontrol);
   assign a_le0 = a[WIDTH-1] | (a == '0);

   muldiv_seq #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk   (clk),
      .reset (reset),
      .start (op_valid & md_op),
      .op    (alucontrol),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   assign stall = op_valid & busy & (md_op | hl_op);

   // result mux; branch codes return 0 when taken
   always_comb begin
      result = '0;
      case (code)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $signed(b) >>> shamt;
         ALU_SLLV: result = b << a[4:0];
         ALU_SRLV: result = b >> a[4:0];
         ALU_SRAV: result = $signed(b) >>> a[4:0];
         ALU_LUI:  result = b << (WIDTH/2);
         ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
         ALU_SLTU: result = WIDTH'(a < b);
         ALU_BLEZ: result = WIDTH'(!a_le0);
         ALU_BGTZ: result = WIDTH'(a_le0);
         ALU_MFHI: result = hi;
         ALU_MFLO: result = lo;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv with a result scoreboard.
// Expected values are pushed at issue and popped at readout.
module tb_alu_muldiv;

   localparam logic [4:0] C_AND   = 5'b00000;
   localparam logic [4:0] C_OR    = 5'b00001;
   localparam logic [4:0] C_ADD   = 5'b00010;
   localparam logic [4:0] C_SLL   = 5'b00011;
   localparam logic [4:0] C_SUB   = 5'b00110;
   localparam logic [4:0] C_SLT   = 5'b00111;
   localparam logic [4:0] C_LUI   = 5'b01000;
   localparam logic [4:0] C_XOR   = 5'b01001;
   localparam logic [4:0] C_BLEZ  = 5'b01010;
   localparam logic [4:0] C_SRLV  = 5'b01011;
   localparam logic [4:0] C_SRL   = 5'b01100;
   localparam logic [4:0] C_SRAV  = 5'b01101;
   localparam logic [4:0] C_SLTU  = 5'b01110;
   localparam logic [4:0] C_BGTZ  = 5'b10000;
   localparam logic [4:0] C_SRA   = 5'b10001;
   localparam logic [4:0] C_SLLV  = 5'b10010;
   localparam logic [4:0] C_MULT  = 5'b10011;
   localparam logic [4:0] C_MULTU = 5'b10100;
   localparam logic [4:0] C_DIV   = 5'b10101;
   localparam logic [4:0] C_DIVU  = 5'b10110;
   localparam logic [4:0] C_MFHI  = 5'b10111;
   localparam logic [4:0] C_MFLO  = 5'b11000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [4:0]  alucontrol = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] result;
   logic        zero;
   logic        stall;
   logic        busy;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   st;

   always #5 clk = ~clk;

   alu_muldiv #(
      .WIDTH (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .alucontrol (alucontrol),
      .a          (a),
      .b          (b),
      .shamt      (shamt),
      .result     (result),
      .zero       (zero),
      .stall      (stall),
      .busy       (busy)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0]  c,
                        input logic [31:0] xa,
                        input logic [31:0] xb,
                        input logic [4:0]  sh);
      op_valid   = 1'b1;
      alucontrol = c;
      a          = xa;
      b          = xb;
      shamt      = sh;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] r, input logic z);
      exp_t e;
      e.res = r;
      e.z   = z;
      sbq.push_back(e);
   endtask

   task automatic comb_op(input string tag,
                          input logic [4:0]  c,
                          input logic [31:0] xa,
                          input logic [31:0] xb,
                          input logic [4:0]  sh,
                          input logic [31:0] r,
                          input logic        z);
      exp_t e;
      push(r, z);
      drive(c, xa, xb, sh);
      @(negedge clk);
      e = sbq.pop_front();
      check(tag, result, e.res);
      check({tag, ".zero"}, {31'b0, zero}, {31'b0, e.z});
      next_cycle();
   endtask

   // hold the current instruction until stall drops (bounded);
   // returns at a negedge with the stalled-cycle count
   task automatic wait_free(input string tag, output int n);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         next_cycle();
      end
      check({tag, ".timeout"}, {31'b0, stall}, 32'd0);
   endtask

   task automatic read_hl(input string tag,
                          input logic [4:0] c,
                          output int n);
      exp_t e;
      drive(c, '0, '0, '0);
      wait_free(tag, n);
      e = sbq.pop_front();
      check(tag, result, e.res);
      next_cycle();
   endtask

   task automatic issue_md(input string tag,
                           input logic [4:0]  c,
                           input logic [31:0] xa,
                           input logic [31:0] xb);
      drive(c, xa, xb, '0);
      @(negedge clk);
      check({tag, ".stall"}, {31'b0, stall}, 32'd0);
      check({tag, ".res"}, result, 32'd0);
      next_cycle();
   endtask

   initial begin
      // reset state
      #1;
      drive(C_MFLO, '0, '0, '0);
      @(negedge clk);
      check("rst.busy", {31'b0, busy}, 32'd0);
      check("rst.stall", {31'b0, stall}, 32'd0);
      check("rst.lo", result, 32'd0);
      alucontrol = C_MFHI;
      #1;
      check("rst.hi", result, 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      // single-cycle ops
      comb_op("add", C_ADD, 32'h7FFFFFFF, 32'h1, 0,
              32'h80000000, 1'b0);
      comb_op("sub", C_SUB, 32'd5, 32'd5, 0, 32'd0, 1'b1);
      comb_op("blez0", C_BLEZ, 32'd0, 32'd9, 0, 32'd0, 1'b1);
      comb_op("bgtz0", C_BGTZ, 32'd0, 32'd9, 0, 32'd1, 1'b0);
      comb_op("blezn", C_BLEZ, 32'hFFFFFFFF, 0, 0,
              32'd0, 1'b1);
      comb_op("blezp", C_BLEZ, 32'd3, 0, 0, 32'd1, 1'b0);
      comb_op("bgtzp", C_BGTZ, 32'd5, 0, 0, 32'd0, 1'b1);
      comb_op("srav", C_SRAV, 32'd4, 32'h80000000, 0,
              32'hF8000000, 1'b0);
      comb_op("sltu", C_SLTU, 32'hFFFFFFFF, 32'd1, 0,
              32'd0, 1'b1);
      comb_op("slt_eq", C_SLT, 32'h1234, 32'h1234, 0,
              32'd0, 1'b1);
      comb_op("slt_neg", C_SLT, 32'hFFFFFFFF, 32'd1, 0,
              32'd1, 1'b0);
      comb_op("and", C_AND, 32'h0000F0F0, 32'h0000FF00, 0,
              32'h0000F000, 1'b0);
      comb_op("or", C_OR, 32'h0000F0F0, 32'h0000FF00, 0,
              32'h0000FFF0, 1'b0);
      comb_op("xor", C_XOR, 32'h0000F0F0, 32'h0000FF00, 0,
              32'h00000FF0, 1'b0);
      comb_op("lui", C_LUI, 32'hDEAD, 32'h1234, 0,
              32'h12340000, 1'b0);
      comb_op("sll", C_SLL, 0, 32'd1, 5'd31,
              32'h80000000, 1'b0);
      comb_op("srl", C_SRL, 0, 32'h80000000, 5'd31,
              32'd1, 1'b0);
      comb_op("sra", C_SRA, 0, 32'h80000000, 5'd4,
              32'hF8000000, 1'b0);
      comb_op("sllv", C_SLLV, 32'h21, 32'd3, 0,
              32'd6, 1'b0);
      comb_op("srlv", C_SRLV, 32'd4, 32'h80000000, 0,
              32'h08000000, 1'b0);
      comb_op("undef", 5'b11111, 32'hFF, 32'hFF, 0,
              32'd0, 1'b1);

      // signed multiply, mflo polled from the next cycle
      push(32'hFFFFFFF1, 1'b0);
      push(32'hFFFFFFFF, 1'b0);
      issue_md("mult", C_MULT, 32'hFFFFFFFD, 32'd5);
      read_hl("mult.lo", C_MFLO, st);
      check("mult.stalls", st, 32'd33);
      read_hl("mult.hi", C_MFHI, st);
      check("mult.hi_stalls", st, 32'd0);

      // signed divide
      push(32'hFFFFFFFD, 1'b0);
      push(32'h00000001, 1'b0);
      issue_md("div", C_DIV, 32'd7, 32'hFFFFFFFE);
      read_hl("div.lo", C_MFLO, st);
      read_hl("div.hi", C_MFHI, st);

      // unsigned divide by zero
      push(32'hFFFFFFFF, 1'b0);
      push(32'h00000007, 1'b0);
      issue_md("divu0", C_DIVU, 32'd7, 32'd0);
      read_hl("divu0.lo", C_MFLO, st);
      read_hl("divu0.hi", C_MFHI, st);

      // signed divide by zero, negative dividend
      push(32'hFFFFFFFF, 1'b0);
      push(32'hFFFFFFF9, 1'b0);
      issue_md("div0", C_DIV, 32'hFFFFFFF9, 32'd0);
      read_hl("div0.lo", C_MFLO, st);
      read_hl("div0.hi", C_MFHI, st);

      // second mul/div while busy waits, then wins HI/LO
      issue_md("mult1", C_MULT, 32'd3, 32'd4);
      push(32'h00000001, 1'b0);
      push(32'hFFFFFFFE, 1'b0);
      drive(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0);
      wait_free("multu", st);
      check("multu.stalls", st, 32'd33);
      next_cycle();
      read_hl("multu.lo", C_MFLO, st);
      check("multu.lo_stalls", st, 32'd33);
      read_hl("multu.hi", C_MFHI, st);

      // reset in the middle of a divide
      issue_md("divr", C_DIV, 32'd100, 32'd7);
      drive(C_ADD, 32'd2, 32'd3, '0);
      @(negedge clk);
      check("busy.add_stall", {31'b0, stall}, 32'd0);
      check("busy.add_res", result, 32'd5);
      check("busy.flag", {31'b0, busy}, 32'd1);
      next_cycle();
      drive(C_MFLO, '0, '0, '0);
      op_valid = 1'b0;
      @(negedge clk);
      check("bubble.stall", {31'b0, stall}, 32'd0);
      next_cycle();
      repeat (7) next_cycle();
      op_valid = 1'b1;
      @(negedge clk);
      check("midrst.stall", {31'b0, stall}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst.busy", {31'b0, busy}, 32'd0);
      check("arst.stall", {31'b0, stall}, 32'd0);
      check("arst.lo", result, 32'd0);
      alucontrol = C_MFHI;
      #1;
      check("arst.hi", result, 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      // divide after reset runs normally
      push(32'd14, 1'b0);
      push(32'd2, 1'b0);
      issue_md("div2", C_DIV, 32'd100, 32'd7);
      read_hl("div2.lo", C_MFLO, st);
      check("div2.stalls", st, 32'd33);
      read_hl("div2.hi", C_MFHI, st);

      op_valid = 1'b0;
      next_cycle();
      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
